// File: rtl/output_stage.sv
// rtl/output_stage.sv - router output stage: phit select, head route shift, packet ownership FSM.
// Optional head counter enabled by macro OUTPUT_STAGE_STATS_EN.
module output_stage #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [3:0]   i_select,
    input  logic         i_shift,
    input  logic [W-1:0] i_d0,
    input  logic [W-1:0] i_d1,
    input  logic [W-1:0] i_d2,
    input  logic [W-1:0] i_d3,
    output logic [W-1:0] o_phit,
    output logic         o_valid,
    output logic         o_err,
    output logic [15:0]  o_pkt_count
);
    localparam logic [1:0] HEAD    = 2'b11;
    localparam logic [1:0] PAYLOAD = 2'b10;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t         r_state;
    logic [3:0]     r_owner;
    logic [W-1:0]   r_phit;
    logic           r_valid;
    logic           r_err;

    logic [W-1:0]   w_sel_phit;
    logic [W-1:0]   w_shifted;
    logic [W-1:0]   w_next_phit;
    logic [1:0]     w_sel_type;
    logic           w_none;
    logic           w_multi;
    logic           w_legal_head;
    logic           w_err_now;

    // Multi-bit or empty grants fall to the default arm, yielding an all-zero idle phit.
    always_comb begin
        w_sel_phit = '0;
        case (i_select)
            4'b0001: w_sel_phit = i_d0;
            4'b0010: w_sel_phit = i_d1;
            4'b0100: w_sel_phit = i_d2;
            4'b1000: w_sel_phit = i_d3;
            default: w_sel_phit = '0;
        endcase
    end

    assign w_none       = (i_select == 4'b0000);
    assign w_multi      = ((i_select & (i_select - 4'd1)) != 4'b0000);
    assign w_sel_type   = w_sel_phit[W-1:W-2];
    // Head phits drop their consumed route field and expose the next one.
    assign w_shifted    = {w_sel_phit[W-1:W-2], w_sel_phit[W-5:0], 2'b00};
    assign w_next_phit  = i_shift ? w_shifted : w_sel_phit;
    assign w_legal_head = i_shift && !w_none && !w_multi && (w_sel_type == HEAD);

    assign w_err_now = w_multi
                    || (i_shift && w_none)
                    || (i_shift && !w_none && (w_sel_type != HEAD))
                    || (!i_shift && !w_none &&
                        ((r_state == S_IDLE) || (i_select != r_owner)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_owner <= 4'b0000;
            r_phit  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_phit  <= w_next_phit;
            r_valid <= w_next_phit[W-1];
            if (w_err_now) begin
                r_err <= 1'b1;
            end
            if (w_none || w_multi) begin
                r_state <= S_IDLE;
                r_owner <= 4'b0000;
            end else if (w_legal_head) begin
                r_state <= S_BUSY;
                r_owner <= i_select;
            end
        end
    end

    assign o_phit  = r_phit;
    assign o_valid = r_valid;
    assign o_err   = r_err;

`ifdef OUTPUT_STAGE_STATS_EN
    logic [15:0] r_pkt_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pkt_count <= 16'd0;
        end else if (w_legal_head) begin
            r_pkt_count <= r_pkt_count + 16'd1;
        end
    end

    assign o_pkt_count = r_pkt_count;
`else
    assign o_pkt_count = 16'd0;
`endif

endmodule

// File: tb/tb_output_stage.sv
// tb/tb_output_stage.sv - directed self-checking bench for output_stage.
module tb_output_stage;
    logic        clk;
    logic        rst;
    logic [3:0]  sel;
    logic        shift;
    logic [15:0] d0, d1, d2, d3;
    logic [15:0] phit;
    logic        valid;
    logic        err;
    logic [15:0] cnt;

    int total = 0;
    int bad   = 0;

    output_stage #(.W(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_select    (sel),
        .i_shift     (shift),
        .i_d0        (d0),
        .i_d1        (d1),
        .i_d2        (d2),
        .i_d3        (d3),
        .o_phit      (phit),
        .o_valid     (valid),
        .o_err       (err),
        .o_pkt_count (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] s, input logic sh);
        sel   = s;
        shift = sh;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sel = 4'b0100; shift = 1'b1;
        d0 = 16'h0; d1 = 16'h0; d2 = 16'hF5A3; d3 = 16'h0;
        // reset dominates a simultaneous legal head
        tick();
        check("rst_phit",  phit, 16'h0000);
        check("rst_valid", {15'd0, valid}, 16'd0);
        check("rst_err",   {15'd0, err}, 16'd0);
        check("rst_cnt",   cnt, 16'd0);
        rst = 1'b0;

        drive(4'b0100, 1'b1);
        tick();
        check("head_phit",  phit, 16'hD68C);
        check("head_valid", {15'd0, valid}, 16'd1);
        check("head_err",   {15'd0, err}, 16'd0);

        d2 = 16'h8123;
        drive(4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pay_phit",  phit, 16'h8123);
            check("pay_valid", {15'd0, valid}, 16'd1);
            check("pay_err",   {15'd0, err}, 16'd0);
        end

        drive(4'b0000, 1'b0);
        tick();
        check("tail_phit",  phit, 16'h0000);
        check("tail_valid", {15'd0, valid}, 16'd0);
        check("tail_err",   {15'd0, err}, 16'd0);

        d0 = 16'hC0FF;
        drive(4'b0001, 1'b1);
        tick();
        check("head0_phit", phit, 16'hC3FC);
        d0 = 16'h9ABC;
        drive(4'b0001, 1'b0);
        tick();
        check("pay0_phit", phit, 16'h9ABC);
        check("pay0_err",  {15'd0, err}, 16'd0);

        d1 = 16'h8000;
        drive(4'b0010, 1'b0);
        tick();
        check("intrude_err", {15'd0, err}, 16'd1);

        for (int i = 0; i < 10; i++) begin
            d3 = 16'hE001;
            drive(4'b1000, 1'b1);
            tick();
            check("legal_head_phit", phit, 16'hC004);
            check("sticky_err", {15'd0, err}, 16'd1);
            d3 = 16'h8000 + 16'(i);
            drive(4'b1000, 1'b0);
            tick();
            check("legal_pay_phit", phit, 16'h8000 + 16'(i));
            drive(4'b0000, 1'b0);
            tick();
            check("legal_idle_phit", phit, 16'h0000);
            check("sticky_err2", {15'd0, err}, 16'd1);
        end
`ifdef OUTPUT_STAGE_STATS_EN
        check("cnt_12", cnt, 16'd12);
`else
        check("cnt_off", cnt, 16'd0);
`endif

        do_reset();
        check("rst2_err", {15'd0, err}, 16'd0);
        d0 = 16'h8111; d1 = 16'h8222;
        drive(4'b0011, 1'b0);
        tick();
        check("multi_phit",  phit, 16'h0000);
        check("multi_valid", {15'd0, valid}, 16'd0);
        check("multi_err",   {15'd0, err}, 16'd1);

        drive(4'b0000, 1'b0);
        do_reset();
        d2 = 16'hF5A3;
        drive(4'b0100, 1'b1);
        tick();
        check("busy_head_phit", phit, 16'hD68C);
        drive(4'b0000, 1'b0);
        do_reset();
        check("midpkt_rst_err", {15'd0, err}, 16'd0);
        d3 = 16'h8000;
        drive(4'b1000, 1'b0);
        tick();
        check("orphan_pay_err", {15'd0, err}, 16'd1);

        drive(4'b0000, 1'b0);
        do_reset();
        drive(4'b0000, 1'b1);
        tick();
        check("shift_nosel_err", {15'd0, err}, 16'd1);

        drive(4'b0000, 1'b0);
        do_reset();
        d0 = 16'h8123;
        drive(4'b0001, 1'b1);
        tick();
        check("shift_pay_err", {15'd0, err}, 16'd1);

        drive(4'b0000, 1'b0);
        do_reset();
        d0 = 16'hC000;
        drive(4'b0001, 1'b1);
`ifdef OUTPUT_STAGE_STATS_EN
        for (int i = 0; i < 65537; i++) tick();
        check("cnt_wrap", cnt, 16'd1);
`else
        for (int i = 0; i < 5; i++) begin
            tick();
            check("cnt_zero", cnt, 16'd0);
        end
`endif
        check("heads_err", {15'd0, err}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/output_stage.md
OUTPUT_STAGE -- requirements
Module: output_stage

Interface
REQ-001 SHALL have parameter W, default 16: phit width in bits, legal range 8..64.
REQ-002 SHALL have port i_clk, input, 1: chip clock, all state updates on rising edge.
REQ-003 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port i_select, input, 4: one-hot grant from the output-port allocator; bit n selects input n.
REQ-005 SHALL have port i_shift, input, 1: high when the selected phit is a newly granted head phit.
REQ-006 SHALL have ports i_d0, i_d1, i_d2, i_d3, input, W each: input phits; [W-1:W-2] type, [W-3:W-4] current route field.
REQ-007 SHALL have port o_phit, output, W: registered output phit.
REQ-008 SHALL have port o_valid, output, 1: o_phit carries a head or payload phit.
REQ-009 SHALL have port o_err, output, 1: sticky protocol error flag.
REQ-010 SHALL have port o_pkt_count, output, 16: heads forwarded (see Configuration).

Function
REQ-011 Phit types SHALL be HEAD=2'b11, PAYLOAD=2'b10; 2'b00 and 2'b01 SHALL be idle.
REQ-012 The selected phit SHALL be the i_dn whose i_select bit n is set; zero select SHALL give idle (all-zero) phit.
REQ-013 On i_shift=1, output SHALL be {type, d[W-3:0] << 2}: type bits kept, route field discarded, two zeros inserted at LSBs.
REQ-014 On i_shift=0, the selected phit SHALL pass unmodified.
REQ-015 Latency SHALL be exactly one cycle: inputs at edge k appear on o_phit/o_valid after edge k+1.
REQ-016 o_valid SHALL be 1 when the registered phit type is HEAD or PAYLOAD, else 0.
REQ-017 FSM SHALL have states IDLE and BUSY, plus a 4-bit register owner.
REQ-018 IDLE -> BUSY SHALL occur when i_shift=1 with one-hot i_select; owner <= i_select.
REQ-019 BUSY SHALL remain BUSY while i_select==owner and the selected type is PAYLOAD.
REQ-020 BUSY with i_shift=1 and one-hot i_select (back-to-back head, same or other input) SHALL stay BUSY; owner <= i_select.
REQ-021 BUSY -> IDLE SHALL occur when i_select==0; o_phit SHALL be 0 that cycle's output.
REQ-022 o_err SHALL set if i_select has more than one bit set; output phit forced to 0; state -> IDLE.
REQ-023 o_err SHALL set if i_shift=1 with i_select==0, or if the selected type is not HEAD while i_shift=1.
REQ-024 o_err SHALL set if, in BUSY, i_select is nonzero, differs from owner, and i_shift=0.
REQ-025 o_err SHALL set if, in IDLE, a nonzero i_select arrives with i_shift=0.
REQ-026 o_err SHALL remain 1 until reset; forwarding of legal traffic SHALL continue after an error.

Reset
REQ-027 With i_rst=1 at a rising edge: o_phit=0, o_valid=0, o_err=0, o_pkt_count=0, state=IDLE, owner=0.
REQ-028 Reset mid-packet SHALL discard the packet; payload arriving after reset deasserts SHALL set o_err per REQ-025.
REQ-029 Reset SHALL take priority over all simultaneous inputs.

Configuration
REQ-030 Macro OUTPUT_STAGE_STATS_EN defined: o_pkt_count SHALL increment by 1 per forwarded head (i_shift=1, legal), wrapping 16'hFFFF -> 0.
REQ-031 OUTPUT_STAGE_STATS_EN undefined: o_pkt_count SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-032 i_select=4'b0100, i_shift=1, i_d2=16'hF5A3 -> next cycle o_phit=16'hD68C, o_valid=1, state BUSY.
REQ-033 Then 3 cycles i_select=4'b0100, i_shift=0, i_d2=16'h8123 -> o_phit=16'h8123 each, o_valid=1; then i_select=0 -> o_phit=0, o_valid=0, IDLE.
REQ-034 In BUSY owner=4'b0001, i_select=4'b0010, i_shift=0 -> o_err=1 and stays 1 through 10 further legal packets.
REQ-035 i_select=4'b0011 -> o_phit=0, o_valid=0, o_err=1 next cycle.
REQ-036 STATS_EN defined: 65537 legal heads -> o_pkt_count=1; undefined -> o_pkt_count=0 throughout.
REQ-037 Reset during BUSY, then i_select=4'b1000, i_shift=0, i_d3=16'h8000 -> o_err=1.
